int_call_responder: RTL and testbench

- Sequential responder for a two-argument integer function call: accepts an (arg1, arg2) request, computes the call's return value, and hands the result back.
- Implements the callee side as hardware: a package-level `int f(int a, int b)` becomes a handshake-driven unit that a caller block instantiates.
- Return value is the signed product `arg1*arg2`, truncated to WIDTH bits (int wrap semantics).
- Computed by an iterative shift-add datapath, one multiplier bit per cycle.

---
 rtl/int_call_responder.sv | 110 +++++++++++
 tb/tb_int_call_responder.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/int_call_responder.sv
// Handshake-driven callee for int f(int a, int b) = a*b mod 2^WIDTH, one shift-add step per cycle.
// Optional completed-call counter port call_count is compiled in with INT_CALL_RESPONDER_COUNT_EN.
//
// state | meaning
// IDLE  | waiting for a request, req_ready high
// CALC  | WIDTH shift-add iterations, busy high
// DONE  | return value presented until taken
module int_call_responder #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] arg1,
  input  logic [WIDTH-1:0] arg2,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] ret,
  output logic             busy
`ifdef INT_CALL_RESPONDER_COUNT_EN
  ,
  output logic [CNT_W-1:0] call_count
`endif
);

  localparam int BW = $clog2(WIDTH);

  if (WIDTH < 2 || WIDTH > 64 || CNT_W < 1) begin : g_bad_param
    $error("int_call_responder: WIDTH must be 2..64 and CNT_W at least 1");
  end

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplr;
  logic [BW-1:0]    bit_cnt;
  logic [WIDTH-1:0] acc_next;

  // Low WIDTH bits of a two's-complement product need no sign correction.
  assign acc_next = mplr[0] ? acc + mcand : acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      mcand     <= '0;
      mplr      <= '0;
      bit_cnt   <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      ret       <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            mcand     <= arg1;
            mplr      <= arg2;
            acc       <= '0;
            bit_cnt   <= '0;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= CALC;
          end
        end
        CALC: begin
          acc     <= acc_next;
          mcand   <= mcand << 1;
          mplr    <= mplr >> 1;
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == BW'(WIDTH - 1)) begin
            ret       <= acc_next;
            rsp_valid <= 1'b1;
            busy      <= 1'b0;
            state     <= DONE;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

`ifdef INT_CALL_RESPONDER_COUNT_EN
  // Counts handshakes only, so aborted calls never reach it.
  always_ff @(posedge clk) begin
    if (rst) begin
      call_count <= '0;
    end else if (state == DONE && rsp_ready) begin
      call_count <= call_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_int_call_responder.sv
// Directed bench for int_call_responder (WIDTH=32); exercises call_count when
// INT_CALL_RESPONDER_COUNT_EN is defined (CNT_W=2 so the wrap is visible).
module tb_int_call_responder;

  localparam int WIDTH = 32;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] arg1;
  logic [WIDTH-1:0] arg2;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] ret;
  logic             busy;
`ifdef INT_CALL_RESPONDER_COUNT_EN
  logic [CNT_W-1:0] call_count;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic [CNT_W-1:0] exp_cnt = '0;

  int_call_responder #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .arg1      (arg1),
    .arg2      (arg2),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .ret       (ret),
    .busy      (busy)
`ifdef INT_CALL_RESPONDER_COUNT_EN
    ,
    .call_count(call_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // hold > 0: keep rsp_ready low for that many cycles in DONE and poke req_valid during CALC.
  task automatic run_call(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [WIDTH-1:0] exp, input int hold);
    int lat;
    int busy_cycles;
    bit stable;
    @(negedge clk);
    check({tag, " req_ready idle"}, 64'(req_ready), 64'd1);
    rsp_ready = (hold == 0);
    req_valid = 1'b1;
    arg1 = a;
    arg2 = b;
    @(posedge clk); #1;
    req_valid = 1'b0;
    arg1 = $urandom;
    arg2 = $urandom;
    lat = 0;
    busy_cycles = 0;
    while (!rsp_valid && lat < 200) begin
      if (busy) busy_cycles++;
      if (hold > 0 && lat == 5) begin
        req_valid = 1'b1;
        arg1 = 32'd9;
        arg2 = 32'd9;
      end else begin
        req_valid = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    req_valid = 1'b0;
    check({tag, " latency"}, 64'(lat), 64'(WIDTH));
    check({tag, " busy cycles"}, 64'(busy_cycles), 64'(WIDTH));
    check({tag, " ret"}, 64'(ret), 64'(exp));
    check({tag, " req_ready in DONE"}, 64'(req_ready), 64'd0);
    if (hold > 0) begin
      stable = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        if (!rsp_valid || ret !== exp || req_ready || busy) stable = 1'b0;
      end
      check({tag, " backpressure hold"}, 64'(stable), 64'd1);
      @(negedge clk);
      rsp_ready = 1'b1;
    end
    @(posedge clk); #1;
    exp_cnt++;
    check({tag, " rsp_valid after handshake"}, 64'(rsp_valid), 64'd0);
    check({tag, " req_ready after handshake"}, 64'(req_ready), 64'd1);
`ifdef INT_CALL_RESPONDER_COUNT_EN
    check({tag, " call_count"}, 64'(call_count), 64'(exp_cnt));
`endif
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    arg1 = '0;
    arg2 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset req_ready", 64'(req_ready), 64'd1);
    check("reset rsp_valid", 64'(rsp_valid), 64'd0);
    check("reset ret", 64'(ret), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
`ifdef INT_CALL_RESPONDER_COUNT_EN
    check("reset call_count", 64'(call_count), 64'd0);
`endif
    @(negedge clk);
    rst = 1'b0;

    run_call("3*5", 32'd3, 32'd5, 32'd15, 0);
    run_call("-7*6", 32'hFFFF_FFF9, 32'd6, 32'hFFFF_FFD6, 0);
    run_call("min*-1", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
    run_call("wrap", 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 0);
    run_call("max*2", 32'h7FFF_FFFF, 32'd2, 32'hFFFF_FFFE, 0);
    run_call("zero", 32'd0, 32'h0001_2345, 32'd0, 0);
    run_call("backpressure", 32'h0000_1234, 32'h0000_0010, 32'h0001_2340, 10);

    // Abort a call with reset on its 10th CALC cycle.
    @(negedge clk);
    req_valid = 1'b1;
    arg1 = 32'd100;
    arg2 = 32'd100;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("abort busy before reset", 64'(busy), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_cnt = '0;
    check("abort req_ready", 64'(req_ready), 64'd1);
    check("abort busy", 64'(busy), 64'd0);
    check("abort rsp_valid", 64'(rsp_valid), 64'd0);
    check("abort ret", 64'(ret), 64'd0);
`ifdef INT_CALL_RESPONDER_COUNT_EN
    check("abort call_count", 64'(call_count), 64'd0);
`endif
    run_call("4*4 after abort", 32'd4, 32'd4, 32'd16, 0);

    // Back-to-back calls; with CNT_W=2 the count runs 2,3,0,1,2 here.
    for (int i = 0; i < 5; i++) begin
      run_call("b2b", 32'(i + 2), 32'hFFFF_FFFD, 32'(-3 * (i + 2)), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not reach its end, expected completion");
    $fatal(1, "timeout");
  end

endmodule
